// File: rtl/siren_detector_pkg.sv
// Shared types and default constants for the siren detector.
package siren_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP_LEG   = 2'd1,
    DOWN_LEG = 2'd2,
    LOCK     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FLAT = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } step_e;

  localparam int unsigned DEF_CNT_W      = 24;
  localparam int unsigned DEF_MIN_PERIOD = 20000;
  localparam int unsigned DEF_MAX_PERIOD = 500000;
  localparam int unsigned DEF_TIMEOUT    = 2000000;
  localparam int unsigned DEF_HYST       = 64;
  localparam int unsigned DEF_SWEEP_N    = 8;

endpackage

// File: rtl/siren_detector_edge_period_meter.sv
// Synchronizes the tone input, detects rising edges and measures the
// edge-to-edge interval with range check and silence timeout.
module edge_period_meter
  import siren_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] sample,
  output logic             sample_valid,
  output logic             silence,
  output logic             timeout_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync2_q, sync2_d_q, edge_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_range;
  logic             armed_q;
  logic [CNT_W-1:0] sample_q;
  logic             sample_valid_q;
  logic             silence_q;

  // Interval length counts the edge cycle itself, so a 100-cycle wave reads 100.
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign in_range  = (cnt_inc >= CNT_W'(MIN_PERIOD)) && (cnt_inc <= CNT_W'(MAX_PERIOD));
  assign timeout_c = !edge_q && (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync2_d_q      <= 1'b0;
      edge_q         <= 1'b0;
      cnt_q          <= '0;
      armed_q        <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      silence_q      <= 1'b1;
    end else begin
      sync1_q        <= tone_in;
      sync2_q        <= sync1_q;
      sync2_d_q      <= sync2_q;
      edge_q         <= sync2_q & ~sync2_d_q;
      sample_valid_q <= 1'b0;
      cnt_q          <= edge_q ? '0 : cnt_inc;
      if (edge_q) begin
        silence_q <= 1'b0;
        armed_q   <= 1'b1;
        // The first edge after reset or silence only opens a measurement window.
        if (armed_q && in_range) begin
          sample_q       <= cnt_inc;
          sample_valid_q <= 1'b1;
        end
      end else if (timeout_c) begin
        silence_q <= 1'b1;
        armed_q   <= 1'b0;
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign silence      = silence_q;

endmodule

// File: rtl/siren_detector.sv
// Siren detector top: period trend classifier FSM over the edge meter.
// Define SIREN_DETECTOR_AVG_EN to publish a 4-sample moving average instead of raw periods.
module siren_detector
  import siren_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned HYST       = DEF_HYST,
  parameter int unsigned SWEEP_N    = DEF_SWEEP_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             siren_detected,
  output logic             silence
);

  localparam int unsigned RUN_W = $clog2(SWEEP_N + 1);
  localparam logic [RUN_W-1:0] RUN_N = RUN_W'(SWEEP_N);

  logic [CNT_W-1:0] sample;
  logic             sample_valid;
  logic             timeout_c;
  logic [CNT_W-1:0] cls_p;
  logic             cls_valid;

  edge_period_meter #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD),
    .MAX_PERIOD (MAX_PERIOD),
    .TIMEOUT    (TIMEOUT)
  ) u_meter (
    .clk          (clk),
    .rst_n        (rst_n),
    .tone_in      (tone_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .silence      (silence),
    .timeout_c    (timeout_c)
  );

`ifdef SIREN_DETECTOR_AVG_EN
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [CNT_W-1:0] h0_q, h1_q, h2_q;
  logic [2:0]       fill_q;
  logic [CNT_W-1:0] avg_q;
  logic             avg_valid_q;
  logic [SUM_W-1:0] sum_c;

  assign sum_c = SUM_W'(sample) + SUM_W'(h0_q) + SUM_W'(h1_q) + SUM_W'(h2_q);

  // Valid only once four fresh samples are in the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_q        <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (timeout_c) begin
        fill_q <= '0;
      end else if (sample_valid) begin
        h0_q        <= sample;
        h1_q        <= h0_q;
        h2_q        <= h1_q;
        fill_q      <= (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
        avg_q       <= CNT_W'(sum_c >> 2);
        avg_valid_q <= (fill_q >= 3'd3);
      end
    end
  end

  assign cls_p        = avg_q;
  assign cls_valid    = avg_valid_q;
`else
  assign cls_p        = sample;
  assign cls_valid    = sample_valid;
`endif

  assign period       = cls_p;
  assign period_valid = cls_valid;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             leg1_done_q, leg1_done_d;
  logic [CNT_W-1:0] prev_period_q, prev_period_d;
  logic             siren_q, siren_d;
  step_e            step_c;
  logic             fwd_c, rev_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      run_cnt_q     <= '0;
      leg1_done_q   <= 1'b0;
      prev_period_q <= '0;
      siren_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      leg1_done_q   <= leg1_done_d;
      prev_period_q <= prev_period_d;
      siren_q       <= siren_d;
    end
  end

  // Shorter period means rising frequency, i.e. an UP step.
  always_comb begin
    step_c = FLAT;
    if (prev_period_q != '0) begin
      if ((prev_period_q > cls_p) && ((prev_period_q - cls_p) > CNT_W'(HYST))) begin
        step_c = UP;
      end else if ((cls_p > prev_period_q) && ((cls_p - prev_period_q) > CNT_W'(HYST))) begin
        step_c = DOWN;
      end
    end
    fwd_c = ((state_q == UP_LEG) && (step_c == UP)) || ((state_q == DOWN_LEG) && (step_c == DOWN));
    rev_c = ((state_q == UP_LEG) && (step_c == DOWN)) || ((state_q == DOWN_LEG) && (step_c == UP));
  end

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    leg1_done_d   = leg1_done_q;
    prev_period_d = prev_period_q;
    if (timeout_c) begin
      state_d       = IDLE;
      run_cnt_d     = '0;
      leg1_done_d   = 1'b0;
      prev_period_d = '0;
    end else if (cls_valid) begin
      prev_period_d = cls_p;
      case (state_q)
        IDLE: begin
          if (step_c == UP) begin
            state_d     = UP_LEG;
            run_cnt_d   = RUN_W'(1);
            leg1_done_d = 1'b0;
          end else if (step_c == DOWN) begin
            state_d     = DOWN_LEG;
            run_cnt_d   = RUN_W'(1);
            leg1_done_d = 1'b0;
          end
        end
        UP_LEG, DOWN_LEG: begin
          if (fwd_c) begin
            run_cnt_d = (run_cnt_q == RUN_N) ? run_cnt_q : run_cnt_q + RUN_W'(1);
          end else if (rev_c) begin
            leg1_done_d = (run_cnt_q == RUN_N);
            state_d     = (state_q == UP_LEG) ? DOWN_LEG : UP_LEG;
            run_cnt_d   = RUN_W'(1);
          end
          if ((fwd_c || rev_c) && (run_cnt_d == RUN_N) && leg1_done_d) begin
            state_d = LOCK;
          end
        end
        LOCK:    state_d = LOCK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    siren_d = (state_d == LOCK);
  end

  assign siren_detected = siren_q;

endmodule

// File: tb/tb_siren_detector.sv
// Scoreboard bench for siren_detector: directed tone intervals, queued expected periods.
module tb_siren_detector;
  import siren_pkg::*;

  localparam int unsigned CNT_W = 24;

  logic             clk;
  logic             rst_n;
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             siren_detected;
  logic             silence;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  siren_detector #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (20),
    .MAX_PERIOD (1000),
    .TIMEOUT    (2000),
    .HYST       (2),
    .SWEEP_N    (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tone_in        (tone_in),
    .period         (period),
    .period_valid   (period_valid),
    .siren_detected (siren_detected),
    .silence        (silence)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // Monitor: every period_valid pulse must match the oldest queued expectation.
  initial begin : monitor
    int want;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && period_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid got=%0d want=none", period);
        end else begin
          want = exp_q.pop_front();
          check("sb_period", longint'(period), longint'(want));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    tone_in = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic first_edge();
    tone_in = 1'b0;
    repeat (4) @(negedge clk);
    tone_in = 1'b1;
  endtask

  // Next rising edge n cycles after the previous one; optionally expect it accepted.
  task automatic interval(input int n, input bit acc);
    repeat (n / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (n - n / 2) @(negedge clk);
    tone_in = 1'b1;
    if (acc) exp_q.push_back(n);
  endtask

  initial begin : stimulus
    int sweep[6] = '{200, 190, 180, 170, 180, 190};
    int broken[5] = '{200, 190, 200, 210, 220};
    int n;
    bit prev_siren;
    bit seen;

    tone_in = 1'b0;
    rst_n   = 1'b0;
    #12;
    check("rst_period", longint'(period), 0);
    check("rst_valid", longint'(period_valid), 0);
    check("rst_siren", longint'(siren_detected), 0);
    check("rst_silence", longint'(silence), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rel_silence", longint'(silence), 1);

    // Constant 100-cycle tone
    first_edge();
    for (int i = 0; i < 5; i++) interval(100, 1'b1);
    repeat (8) @(negedge clk);
    check("const_period", longint'(period), 100);
    check("const_state", longint'(dut.state_q), longint'(IDLE));
    check("const_siren", longint'(siren_detected), 0);
    check("const_silence", longint'(silence), 0);

    // Sweep 200..170..200, then silence while locked
    do_reset();
    first_edge();
    foreach (sweep[i]) interval(sweep[i], 1'b1);
    interval(200, 1'b1);
    n = 0;
    seen = 1'b0;
    prev_siren = 1'b0;
    for (int k = 1; k <= 2200; k++) begin
      prev_siren = siren_detected;
      @(negedge clk);
      if (k == 4) begin
        check("sweep_valid_at4", longint'(period_valid), 1);
        check("sweep_siren_at4", longint'(siren_detected), 0);
      end
      if (k == 5) begin
        check("sweep_siren_at5", longint'(siren_detected), 1);
        check("sweep_state_lock", longint'(dut.state_q), longint'(LOCK));
      end
      if (k == 50) tone_in = 1'b0;
      if (silence) begin
        n = k;
        seen = 1'b1;
        break;
      end
    end
    check("silence_seen", longint'(seen), 1);
    check("silence_cycle", longint'(n), 2005);
    check("silence_prev_siren", longint'(prev_siren), 1);
    check("silence_siren", longint'(siren_detected), 0);
    check("silence_state", longint'(dut.state_q), longint'(IDLE));

    // Broken first leg: no lock
    do_reset();
    first_edge();
    foreach (broken[i]) interval(broken[i], 1'b1);
    repeat (8) @(negedge clk);
    check("broken_state", longint'(dut.state_q), longint'(DOWN_LEG));
    check("broken_run", longint'(dut.run_cnt_q), 3);
    check("broken_leg1", longint'(dut.leg1_done_q), 0);
    check("broken_siren", longint'(siren_detected), 0);

    // Out-of-range intervals are discarded
    do_reset();
    first_edge();
    interval(200, 1'b1);
    interval(190, 1'b1);
    interval(10, 1'b0);
    interval(1500, 1'b0);
    repeat (8) @(negedge clk);
    check("oor_period", longint'(period), 190);
    check("oor_state", longint'(dut.state_q), longint'(UP_LEG));
    check("oor_run", longint'(dut.run_cnt_q), 1);
    check("oor_silence", longint'(silence), 0);

    // Asynchronous reset between clock edges while in UP_LEG
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    tone_in = 1'b0;
    #1;
    check("amid_period", longint'(period), 0);
    check("amid_valid", longint'(period_valid), 0);
    check("amid_siren", longint'(siren_detected), 0);
    check("amid_silence", longint'(silence), 1);
    check("amid_state", longint'(dut.state_q), longint'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    first_edge();
    interval(100, 1'b1);
    repeat (8) @(negedge clk);
    check("post_rst_period", longint'(period), 100);

    repeat (10) @(negedge clk);
    check("sb_drained", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
